// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: F-stage PC sequencer with req/ack imem handshake and delay-slot redirect (FETCH_ALIGN_CHK_EN adds exc_adel_F)
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        valid_D,
  input  logic [2:0]  npc_mode_D,
  input  logic        cmp_res_D,
  input  logic [25:0] imm26_D,
  input  logic [31:0] rs_val_D,
  input  logic [31:0] pc_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] instr_F,
  output logic        instr_valid_F,
`ifdef FETCH_ALIGN_CHK_EN
  output logic        exc_adel_F,
`endif
  output logic        fetch_fire
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, held_q, held_d, redir_pc_q, redir_pc_d;
  logic        redir_pending_q, redir_pending_d;
  logic [31:0] branch_tgt, jump_tgt, target;
  logic        take, adel;
  assign branch_tgt = pc_D + 32'd4 + {{14{imm26_D[15]}}, imm26_D[15:0], 2'b00};
  assign jump_tgt   = {pc_D[31:28], imm26_D, 2'b00};
  assign target     = npc_mode_D == 3'd1 ? branch_tgt : npc_mode_D == 3'd2 ? jump_tgt : rs_val_D;
  assign take       = valid_D & ~stall_D &
                      ((npc_mode_D == 3'd1 & cmp_res_D) | npc_mode_D == 3'd2 | npc_mode_D == 3'd3);
  assign pc_F       = pc_q;
  assign imem_addr  = pc_q;
`ifdef FETCH_ALIGN_CHK_EN
  assign adel       = state_q != S_IDLE &&
                      (pc_q[1:0] != 2'b00 || pc_q < 32'h0000_3000 || pc_q > 32'h0000_6FFC);
  assign exc_adel_F = adel;
`else
  assign adel       = 1'b0;
`endif
  // handshake FSM: next state, held word and F outputs; a bad address yields a nop without touching memory
  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    imem_req      = 1'b0;
    instr_valid_F = 1'b0;
    instr_F       = '0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req      = ~adel;
        instr_valid_F = adel | imem_ack;
        instr_F       = adel ? 32'd0 : imem_rdata;
        if (imem_ack & stall_D & ~adel) begin
          state_d = S_HOLD;
          held_d  = imem_rdata;
        end
      end
      S_HOLD: begin
        instr_valid_F = 1'b1;
        instr_F       = held_q;
        state_d       = stall_D ? S_HOLD : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    fetch_fire = instr_valid_F & ~stall_D;
  end
  // PC sequencing: a redirect seen before the delay slot leaves F is parked until it does
  always_comb begin
    pc_d            = pc_q;
    redir_pc_d      = take & ~fetch_fire ? target : redir_pc_q;
    redir_pending_d = fetch_fire ? 1'b0 : take | redir_pending_q;
    if (fetch_fire)
      pc_d = take ? target : redir_pending_q ? redir_pc_q : pc_q + 32'd4;
  end
  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      held_q          <= '0;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      held_q          <= held_d;
      redir_pending_q <= redir_pending_d;
      redir_pc_q      <= redir_pc_d;
    end
  end
endmodule
